uart_tx: RTL and testbench

- Serial UART transmitter; the outbound counterpart of the MIPS UART receive path (SerialDataIn / Rx_flag / DataRx).
- Lets the MIPS core or a GPIO/peripheral bridge send bytes to a host over a single asynchronous line.
- Serializes one parallel word per request as: start bit, data bits LSB-first, optional parity, 1 or 2 stop bits.
- Runs in the single clk domain (50 MHz board clock).

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Sends one DATA_BITS-wide word per accepted request on SerialDataOut as
// start bit, data LSB-first, optional parity bit, then 1 or 2 stop bits.
// Every bit lasts CLKS_PER_BIT clocks and all outputs are registered.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 SerialDataOut,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic              PAR_INV   = (PARITY_ODD != 0);
    localparam bit                HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [3:0]            bit_cnt;     // data bit index in DATA, stop bit index in STOP
    logic [DATA_BITS-1:0]  shift_reg;   // bits still to send, next one in [0]
    logic                  parity_bit;
    logic                  baud_wrap;

    // Last clock of the current bit period.
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // Frame sequencer: baud timing, bit sequencing and registered line/status outputs.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later statements see
    // half-updated state and change behaviour with statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: shift_reg and parity_bit are deliberately left out of reset;
            // they are always loaded at request acceptance before being used, so
            // resetting them would only add reset fan-out to pure datapath flops.
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            SerialDataOut <= 1'b1;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    SerialDataOut <= 1'b1;
                    tx_busy       <= 1'b0;
                    baud_cnt      <= '0;
                    bit_cnt       <= '0;
                    if (tx_start) begin
                        // The start bit goes out from this very edge, so the
                        // baud counter begins the start-bit period at 0 now.
                        shift_reg     <= tx_data;
                        parity_bit    <= (^tx_data) ^ PAR_INV;
                        SerialDataOut <= 1'b0;
                        tx_busy       <= 1'b1;
                        state         <= START;
                    end
                end

                START: begin
                    if (baud_wrap) begin
                        SerialDataOut <= shift_reg[0];
                        shift_reg     <= {1'b0, shift_reg[DATA_BITS-1:1]};
                        bit_cnt       <= '0;
                        state         <= DATA;
                    end
                end

                DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                SerialDataOut <= parity_bit;
                                state         <= PARITY;
                            end else begin
                                SerialDataOut <= 1'b1;
                                state         <= STOP;
                            end
                        end else begin
                            SerialDataOut <= shift_reg[0];
                            shift_reg     <= {1'b0, shift_reg[DATA_BITS-1:1]};
                            bit_cnt       <= bit_cnt + 4'd1;
                        end
                    end
                end

                PARITY: begin
                    if (baud_wrap) begin
                        SerialDataOut <= 1'b1;
                        bit_cnt       <= '0;
                        state         <= STOP;
                    end
                end

                STOP: begin
                    if (baud_wrap) begin
                        if (bit_cnt == STOP_LAST) begin
                            // The cycle spent in IDLE with tx_done high is the
                            // earliest point a following request can be sampled.
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    SerialDataOut <= 1'b1;
                    tx_busy       <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx across several frame formats.
// Each configuration has its own stimulus process, which decides from frame
// arithmetic whether a request is accepted and queues the expected word, and
// its own monitor, which compares every line cycle against the frame shape.
module tb_uart_tx;

    localparam int NCFG = 4;
    localparam int CPB_A [NCFG] = '{4, 4, 3, 4};
    localparam int DB_A  [NCFG] = '{8, 8, 7, 8};
    localparam int PE_A  [NCFG] = '{0, 1, 1, 0};
    localparam int PO_A  [NCFG] = '{0, 0, 1, 0};
    localparam int SB_A  [NCFG] = '{1, 1, 2, 2};

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fin = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int         CPB   = CPB_A[g];
        localparam int         DB    = DB_A[g];
        localparam int         PE    = PE_A[g];
        localparam int         PO    = PO_A[g];
        localparam int         SB    = SB_A[g];
        localparam int         N     = CPB * (1 + DB + PE + SB);
        localparam logic [8:0] MASK  = 9'((1 << DB) - 1);

        logic          rst = 1'b1;
        logic          tx_start = 1'b0;
        logic [DB-1:0] tx_data = '0;
        logic          line;
        logic          busy;
        logic          done;
        logic          rst_q = 1'b0;

        logic [8:0] exp_q [$];
        int         edge_cnt = 0;
        int         free_at = 0;

        bit         active = 1'b0;
        bit         expect_done = 1'b0;
        int         pos = 0;
        int         errs = 0;
        int         idle_errs = 0;
        logic [8:0] cur = '0;
        logic [8:0] got = '0;

        uart_tx #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO),
            .STOP_BITS    (SB)
        ) dut (
            .clk           (clk),
            .reset         (rst),
            .tx_start      (tx_start),
            .tx_data       (tx_data),
            .SerialDataOut (line),
            .tx_busy       (busy),
            .tx_done       (done)
        );

        // Line level of frame bit idx for word d: start 0, data LSB-first,
        // optional parity, then stop bits at 1.
        function automatic logic ref_bit(input logic [8:0] d, input int idx);
            if (idx == 0) return 1'b0;
            if (idx <= DB) return d[idx-1];
            if (PE != 0 && idx == DB + 1) return (^d) ^ (PO != 0);
            return 1'b1;
        endfunction

        // Drive one clock of inputs and predict acceptance at the coming edge:
        // a request is taken once the previous frame plus its tx_done cycle
        // have elapsed; reset makes the next edge free again.
        task automatic cyc(input logic s, input logic [8:0] d, input logic r);
            int         e;
            logic [8:0] dm;
            dm       = d & MASK;
            tx_start = s;
            tx_data  = dm[DB-1:0];
            rst      = r;
            e        = edge_cnt + 1;
            if (r) begin
                free_at = e + 1;
            end else if (s && e >= free_at) begin
                exp_q.push_back(dm);
                free_at = e + N + 1;
            end
            @(posedge clk);
            #1;
            edge_cnt++;
        endtask

        task automatic send(input logic [8:0] d);
            cyc(1'b1, d, 1'b0);
            repeat (N + 1) cyc(1'b0, 9'($urandom), 1'b0);
        endtask

        // Reset as seen by the DUT at the last edge.
        always @(posedge clk) rst_q <= rst;

        // Monitor: pop an expected word when a frame starts, then compare every cycle.
        always @(negedge clk) begin
            if (rst_q) begin
                active      = 1'b0;
                expect_done = 1'b0;
                check($sformatf("cfg%0d reset", g), line === 1'b1 && busy === 1'b0 && done === 1'b0,
                      $sformatf("line=%b busy=%b done=%b, want 1 0 0", line, busy, done));
            end else if (expect_done) begin
                expect_done = 1'b0;
                check($sformatf("cfg%0d frame", g),
                      errs == 0 && done === 1'b1 && busy === 1'b0 && line === 1'b1,
                      $sformatf("got data %h done=%b busy=%b line=%b bad_cycles=%0d, want data %h done=1 busy=0 line=1",
                                got, done, busy, line, errs, cur));
            end else begin
                if (!active && busy === 1'b1 && exp_q.size() > 0) begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    pos    = 0;
                    errs   = 0;
                    got    = '0;
                end
                if (active) begin
                    if (line !== ref_bit(cur, pos / CPB) || busy !== 1'b1 || done !== 1'b0) errs++;
                    if ((pos % CPB) == CPB / 2 && pos / CPB >= 1 && pos / CPB <= DB)
                        got[pos/CPB-1] = line;
                    pos++;
                    if (pos == N) begin
                        active      = 1'b0;
                        expect_done = 1'b1;
                    end
                end else if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                    idle_errs++;
                end
            end
        end

        // Directed scenarios followed by sparse and dense random traffic.
        initial begin
            repeat (3) cyc(1'b0, 9'h000, 1'b1);
            repeat (20) cyc(1'b0, 9'h000, 1'b0);
            send(9'h055);
            send(9'h007);
            send(9'h1FF);
            send(9'h000);

            // Requests during a frame must be ignored and data changes unseen.
            cyc(1'b1, 9'h0A3, 1'b0);
            for (int k = 1; k <= N + 1; k++)
                cyc(k == 10 || k == 25, (k == 10 || k == 25) ? 9'h0FF : 9'($urandom), 1'b0);

            // Reset 17 cycles into a frame aborts it; a new request then works.
            cyc(1'b1, 9'h05A, 1'b0);
            repeat (16) cyc(1'b0, 9'h000, 1'b0);
            cyc(1'b0, 9'h000, 1'b1);
            repeat (3) cyc(1'b0, 9'h000, 1'b0);
            send(9'h03C);

            // Request held high: frames repeat, each capturing its own data.
            cyc(1'b1, 9'h081, 1'b0);
            repeat (N + 1) cyc(1'b1, 9'h018, 1'b0);
            repeat (N + 2) cyc(1'b0, 9'h000, 1'b0);

            for (int round = 0; round < 2; round++) begin
                repeat (20 * N) begin
                    cyc(round == 0 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0),
                        9'($urandom), $urandom_range(0, 399) == 0);
                end
            end

            repeat (N + 3) cyc(1'b0, 9'h000, 1'b0);
            check($sformatf("cfg%0d drain", g), exp_q.size() == 0 && !active && !expect_done,
                  $sformatf("pending=%0d active=%0d, want 0 0", exp_q.size(), active));
            check($sformatf("cfg%0d idle", g), idle_errs == 0,
                  $sformatf("bad idle cycles=%0d, want 0", idle_errs));
            n_fin++;
        end
    end

    // Wait for every configuration (bounded), then report.
    initial begin
        int budget;
        budget = 0;
        while (n_fin < NCFG && budget < 60000) begin
            @(posedge clk);
            budget++;
        end
        if (n_fin < NCFG)
            check("timeout", 1'b0, $sformatf("finished=%0d, want %0d", n_fin, NCFG));
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
